run_dump_ctrl: RTL
==================

# run_dump_ctrl

Run-and-dump sequencer for the single-cycle MIPS core and its data memory. It holds the core in reset and then releases it. It watches the fetched instruction stream for end-of-program (a run of NOPs) or a watchdog expiry, then freezes the core and takes over the data memory port. Finally it streams the first DUMP_WORDS words out over a valid/ready interface. It sits between `single_cycle_mips` and `datamem` and makes result checking possible on silicon/FPGA without a testbench.

## Interface
- TIMEOUT, 9, consecutive `inst == 0` cycles that mark program end
- WATCHDOG, 500, max RUN cycles before forced stop
- RST_CYCLES, 10, cycles core reset is held after `start`
- DUMP_WORDS, 22, words dumped from byte address 0 (1..256)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE
- inst  in  32  instruction currently fetched by the core
- cpu_data_addr / cpu_data_in  in  32  core data-memory address / write data
- cpu_data_wr  in  1  core write enable
- mem_data_addr / mem_data_in  out  32  to datamem
- mem_data_wr  out  1  to datamem
- mem_data_out  in  32  datamem read data, combinational from mem_data_addr
- core_rst_n  out  1  active-low reset to the core, registered
- dump_valid  out  1  dump word available
- dump_ready  in  1  consumer accepts word
- dump_data  out  32  = mem_data_out during DUMP
- dump_idx  out  8  word index of dump_data
- busy / done / timed_out  out  1  status

## Operation
- States:
  - IDLE: entered on reset; start → RESET.
  - RESET: counter runs 0..RST_CYCLES-1; at the end → RUN.
  - RUN: NOP end or watchdog → DUMP.
  - DUMP: after the last word is accepted → DONE.
  - DONE: start → RESET.
- Memory mux:
  - RUN: mem_* = cpu_*.
  - All other states: mem_data_addr = {dump_idx, 2'b00} zero-extended; mem_data_in = 0; mem_data_wr = 0.
- core_rst_n = 1 only in RUN; the core is frozen (held in reset) in DUMP/DONE, so memory is unchanged during the dump.
- RUN counters, updated every RUN cycle:
  - nop_cnt: +1 if inst == 0, else cleared.
  - watch_cnt: +1 every cycle.
  - Both cleared on entering RUN.
- Exit RUN on the edge where nop_cnt reaches TIMEOUT or watch_cnt reaches WATCHDOG.
  - timed_out = 1 only if the watchdog hit and the NOP limit did not. If both hit on the same edge, the NOP limit wins and timed_out = 0.
- DUMP:
  - dump_valid = 1; dump_idx starts at 0.
  - On dump_valid && dump_ready: idx+1. If idx == DUMP_WORDS-1 → DONE.
  - The word is held stable while !dump_ready.
- start in RESET/RUN/DUMP is ignored. start in DONE clears done and timed_out and restarts; memory contents are not cleared.
- rst asserted at any time (including mid-DUMP) → IDLE immediately, with all counters cleared.

## Timing
- Reset values: core_rst_n = 0, dump_valid = 0, dump_idx = 0, busy = 0, done = 0, timed_out = 0, mem_data_wr = 0, mem_data_addr = 0, mem_data_in = 0.
- start sampled at edge T → RESET from T.
  - core_rst_n rises at edge T+RST_CYCLES (first RUN cycle).
- busy = 1 in RESET/RUN/DUMP. done = 1 in DONE only.
- A program whose last real instruction is fetched in RUN cycle k, followed by NOPs, enters DUMP at the end of cycle k+TIMEOUT.
- dump_valid asserts in the first DUMP cycle.
  - Word i is visible in the same cycle its idx is presented (combinational memory read).
  - Throughput is 1 word/cycle with dump_ready held high.
- DUMP length with ready always high: exactly DUMP_WORDS cycles.

## Configuration
- RUN_DUMP_CHECKSUM_EN:
  - Defined: adds output `dump_sum` (32). It is cleared on entering RESET and accumulates a wrapping 32-bit sum of every accepted dump word. It is valid in DONE.
  - Undefined: the port and logic are absent; all other behaviour is identical.

## Test plan
- Program storing 0x11,0x22 at words 0,1, then NOPs; start pulse, ready=1 → core_rst_n high 10 cycles after start, DUMP after 9 NOPs, dump words 0,1 = 0x00000011, 0x00000022, 22 words total, done=1, timed_out=0.
- Infinite loop (beq to self), WATCHDOG=500 → exactly 500 RUN cycles, then DUMP, timed_out=1, core_rst_n=0 throughout DUMP.
- dump_ready toggled 1,0,0,1… → dump_idx/dump_data hold while ready=0, no word skipped or duplicated, 22 handshakes total.
- rst asserted at dump_idx=5 → next cycle IDLE, dump_valid=0, busy=0. A following start restarts from RESET with dump_idx=0.
- NOP limit and watchdog hit on the same edge (WATCHDOG=20, NOPs from RUN cycle 11) → DUMP, timed_out=0. start pulse during RUN has no effect.
- With RUN_DUMP_CHECKSUM_EN: words 0..21 = 1..22 → dump_sum = 253. Rerun clears the sum before accumulating again.

Source files
------------

// File: rtl/run_dump_ctrl.sv
// run_dump_ctrl: run-and-dump sequencer between single_cycle_mips and datamem.
//
// Holds the core in reset after a start request and then releases it. It watches the fetched
// instruction stream for a run of NOPs (program end) or a watchdog expiry, then freezes the
// core, takes over the data-memory port and streams the first DUMP_WORDS words out over a
// valid/ready interface.
//
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   start                        one-cycle run request, honoured in IDLE or DONE only
//   inst                         instruction currently fetched by the core
//   cpu_data_addr/_in/_wr        core-side data-memory request
//   mem_data_addr/_in/_wr        datamem-side request (core in RUN, dump address otherwise)
//   mem_data_out                 datamem read data, combinational from mem_data_addr
//   core_rst_n                   registered active-low core reset, high only in RUN
//   dump_valid/ready/data/idx    dump stream and word index
//   busy, done, timed_out        status
//
// Optional feature (macro RUN_DUMP_CHECKSUM_EN): adds output dump_sum, a wrapping 32-bit sum
// of every accepted dump word, cleared on entering RESET.
module run_dump_ctrl #(
  parameter int unsigned TIMEOUT    = 9,
  parameter int unsigned WATCHDOG   = 500,
  parameter int unsigned RST_CYCLES = 10,
  parameter int unsigned DUMP_WORDS = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] inst,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_in,
  input  logic        cpu_data_wr,
  output logic [31:0] mem_data_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_data_wr,
  input  logic [31:0] mem_data_out,
  output logic        core_rst_n,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic [7:0]  dump_idx,
  output logic        busy,
  output logic        done,
  output logic        timed_out
`ifdef RUN_DUMP_CHECKSUM_EN
  ,
  output logic [31:0] dump_sum
`endif
);

  localparam int unsigned RstW = $clog2(RST_CYCLES + 1);
  localparam int unsigned NopW = $clog2(TIMEOUT + 1);
  localparam int unsigned WdW  = $clog2(WATCHDOG + 1);

  localparam logic [RstW-1:0] RstLast = RstW'(RST_CYCLES - 1);
  localparam logic [NopW-1:0] NopMax  = NopW'(TIMEOUT);
  localparam logic [WdW-1:0]  WdMax   = WdW'(WATCHDOG);
  localparam logic [7:0]      IdxLast = 8'(DUMP_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StReset, StRun, StDump, StDone} state_e;

  state_e          state_q, state_d;
  logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
  logic [NopW-1:0] nop_cnt_q, nop_cnt_d;
  logic [WdW-1:0]  watch_cnt_q, watch_cnt_d;
  logic [7:0]      idx_q, idx_d;
  logic            timed_out_q, timed_out_d;
  logic            core_rst_n_q;
  logic            nop_hit, wd_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rst_cnt_q    <= '0;
      nop_cnt_q    <= '0;
      watch_cnt_q  <= '0;
      idx_q        <= '0;
      timed_out_q  <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      nop_cnt_q    <= nop_cnt_d;
      watch_cnt_q  <= watch_cnt_d;
      idx_q        <= idx_d;
      timed_out_q  <= timed_out_d;
      // Registered so the core sees a clean release on the first RUN edge.
      core_rst_n_q <= (state_d == StRun);
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    nop_cnt_d   = nop_cnt_q;
    watch_cnt_d = watch_cnt_q;
    idx_d       = idx_q;
    timed_out_d = timed_out_q;
    nop_hit     = 1'b0;
    wd_hit      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StReset;
          rst_cnt_d   = '0;
          idx_d       = '0;
          timed_out_d = 1'b0;
        end
      end
      StReset: begin
        if (rst_cnt_q == RstLast) begin
          state_d     = StRun;
          nop_cnt_d   = '0;
          watch_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StRun: begin
        nop_cnt_d   = (inst == '0) ? nop_cnt_q + 1'b1 : '0;
        watch_cnt_d = watch_cnt_q + 1'b1;
        nop_hit     = (nop_cnt_d == NopMax);
        wd_hit      = (watch_cnt_d == WdMax);
        if (nop_hit || wd_hit) begin
          state_d     = StDump;
          idx_d       = '0;
          // NOP end takes priority when both limits land on the same edge.
          timed_out_d = wd_hit && !nop_hit;
        end
      end
      StDump: begin
        if (dump_ready) begin
          if (idx_q == IdxLast) begin
            state_d = StDone;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory port: the core owns it only while running; otherwise it is a read-only dump port.
  always_comb begin
    if (state_q == StRun) begin
      mem_data_addr = cpu_data_addr;
      mem_data_in   = cpu_data_in;
      mem_data_wr   = cpu_data_wr;
    end else begin
      mem_data_addr = {22'd0, idx_q, 2'b00};
      mem_data_in   = '0;
      mem_data_wr   = 1'b0;
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign dump_valid = (state_q == StDump);
  assign dump_data  = dump_valid ? mem_data_out : '0;
  assign dump_idx   = idx_q;
  assign busy       = (state_q == StReset) || (state_q == StRun) || (state_q == StDump);
  assign done       = (state_q == StDone);
  assign timed_out  = timed_out_q;

`ifdef RUN_DUMP_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        enter_reset;

  assign enter_reset = ((state_q == StIdle) || (state_q == StDone)) && start;

  always_comb begin
    sum_d = sum_q;
    if (enter_reset) begin
      sum_d = '0;
    end else if (dump_valid && dump_ready) begin
      sum_d = sum_q + mem_data_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign dump_sum = sum_q;
`endif

endmodule
